lsu_axi_ctrl: RTL and testbench

Load/store sequencer between the MEM stage of the 5-stage RV32I pipeline and the data-side AXI4 master port. It accepts the decoded memory request (read/write, funct3, byte strobe), aligns address, strobe and data to the 32-bit bus, and runs one single-beat AXI4 transaction per request. While the transaction is in flight it stalls the pipeline. On completion it returns sign- or zero-extended load data for writeback.

---
 rtl/lsu_axi_ctrl_if.sv | 70 +++++++
 rtl/lsu_axi_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_lsu_axi_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_axi_ctrl_if.sv
// ============================================================================
// Module      : lsu_axi_ctrl_if
// Description : Single-beat AXI4 data-side bus between the load/store
//               sequencer (master) and the memory interconnect (slave).
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface lsu_axi_ctrl_if #(
  parameter int ADDR_W = 32
);
  // write address channel
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  // write data channel
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  // write response channel
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  // read address channel
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  // read data channel
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

`default_nettype wire

// File: rtl/lsu_axi_ctrl.sv
// ============================================================================
// Module      : lsu_axi_ctrl
// Description : MEM-stage load/store sequencer. Aligns a decoded RV32I memory
//               request onto a 32-bit AXI4 bus, runs one single-beat
//               transaction, stalls the pipeline meanwhile and returns
//               extended load data.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lsu_axi_ctrl #(
  parameter int ADDR_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              req_valid,
  input  wire logic              req_read,
  input  wire logic              req_write,
  input  wire logic [2:0]        req_funct3,
  input  wire logic [3:0]        req_strb,
  input  wire logic [ADDR_W-1:0] req_addr,
  input  wire logic [31:0]       req_wdata,
  output logic                   stall,
  output logic                   done,
  output logic [31:0]            rdata_out,
  output logic                   err,
  lsu_axi_ctrl_if.master         axi
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_AR   = 3'd1,
    S_RD_R    = 3'd2,
    S_WR_AW_W = 3'd3,
    S_WR_B    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic [2:0]         r_funct3;
  logic [1:0]         r_off;
  logic               r_aw_done;
  logic               r_w_done;
  logic               r_resp_err;
  logic [31:0]        r_rdata_out;

  logic               w_mem;
  logic               w_misal;
  logic               w_start;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_b_hs;
  logic               w_ar_hs;
  logic               w_r_hs;
  logic               w_awvalid;
  logic               w_wvalid;
  logic               w_arvalid;
  logic               w_rready;
  logic               w_bready;
  logic [31:0]        w_shift;
  logic [31:0]        w_load_ext;

  // funct3[1] marks a word access, funct3[1:0]==01 a halfword access
  assign w_mem   = req_valid & (req_read | req_write);
  assign w_misal = (req_funct3[1] & (|req_addr[1:0])) |
                   ((req_funct3[1:0] == 2'b01) & req_addr[0]);
  assign w_start = (r_state == S_IDLE) & w_mem & ~w_misal;

  assign w_aw_hs = w_awvalid & axi.awready;
  assign w_w_hs  = w_wvalid  & axi.wready;
  assign w_b_hs  = w_bready  & axi.bvalid;
  assign w_ar_hs = w_arvalid & axi.arready;
  assign w_r_hs  = w_rready  & axi.rvalid;

  // state register; reset returns to IDLE with every valid low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode plus handshake and pipeline control outputs
  always_comb begin
    w_state_nxt = r_state;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_bready    = 1'b0;
    stall       = w_start;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        // misaligned access is reported and dropped without touching the bus
        err = w_mem & w_misal;
        if (w_start) begin
          w_state_nxt = req_read ? S_RD_AR : S_WR_AW_W;
        end
      end
      S_RD_AR: begin
        w_arvalid = 1'b1;
        stall     = 1'b1;
        if (axi.arready) begin
          w_state_nxt = S_RD_R;
        end
      end
      S_RD_R: begin
        w_rready = 1'b1;
        stall    = 1'b1;
        if (axi.rvalid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_WR_AW_W: begin
        // AW and W retire independently; leave once both have handshaken
        w_awvalid = ~r_aw_done;
        w_wvalid  = ~r_w_done;
        stall     = 1'b1;
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          w_state_nxt = S_WR_B;
        end
      end
      S_WR_B: begin
        w_bready = 1'b1;
        stall    = 1'b1;
        if (axi.bvalid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        err         = r_resp_err;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // move the addressed byte/half down to bit 0, then extend by funct3
  always_comb begin
    w_shift = axi.rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load_ext = {24'd0, w_shift[7:0]};
      3'b001:  w_load_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_load_ext = {16'd0, w_shift[15:0]};
      default: w_load_ext = w_shift;
    endcase
  end

  // request latch at start, channel-done flags and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_resp_err  <= 1'b0;
      r_rdata_out <= '0;
    end else begin
      if (w_start) begin
        r_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
        r_wstrb    <= req_strb << req_addr[1:0];
        r_wdata    <= req_wdata << {req_addr[1:0], 3'b000};
        r_funct3   <= req_funct3;
        r_off      <= req_addr[1:0];
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
        r_resp_err <= 1'b0;
      end
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
      end
      if (w_r_hs) begin
        r_resp_err  <= |axi.rresp;
        r_rdata_out <= (|axi.rresp) ? 32'd0 : w_load_ext;
      end
      if (w_b_hs) begin
        r_resp_err <= |axi.bresp;
      end
    end
  end

  assign rdata_out   = r_rdata_out;

  assign axi.awaddr  = r_addr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = w_awvalid;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_wvalid;
  assign axi.bready  = w_bready;
  assign axi.araddr  = r_addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = w_arvalid;
  assign axi.rready  = w_rready;

endmodule

`default_nettype wire

// File: tb/tb_lsu_axi_ctrl.sv
// ============================================================================
// Module      : tb_lsu_axi_ctrl
// Description : Self-checking bench for lsu_axi_ctrl with a configurable
//               single-beat AXI slave and a table of load/store vectors.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lsu_axi_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [3:0]  req_strb = 4'b0000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall;
  logic        done;
  logic [31:0] rdata_out;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_axi_ctrl_if #(.ADDR_W(32)) axi ();

  lsu_axi_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_strb   (req_strb),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .rdata_out  (rdata_out),
    .err        (err),
    .axi        (axi.master)
  );

  // ---------------- slave model ----------------
  int          cfg_ar_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_rsp_dly = 0;
  logic [31:0] cfg_rdata = 32'd0;
  logic [1:0]  cfg_resp = 2'b00;

  int          ar_cnt, aw_cnt, w_cnt, rsp_cnt, w_beats;
  logic        r_pend, b_pend, aw_got, w_got;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [3:0]  seen_wstrb;

  assign axi.arready = axi.arvalid && (ar_cnt >= cfg_ar_dly);
  assign axi.awready = axi.awvalid && (aw_cnt >= cfg_aw_dly);
  assign axi.wready  = axi.wvalid  && (w_cnt  >= cfg_w_dly);
  assign axi.rvalid  = r_pend && (rsp_cnt >= cfg_rsp_dly);
  assign axi.bvalid  = b_pend && (rsp_cnt >= cfg_rsp_dly);
  assign axi.rdata   = cfg_rdata;
  assign axi.rresp   = axi.rvalid ? cfg_resp : 2'b00;
  assign axi.bresp   = axi.bvalid ? cfg_resp : 2'b00;

  wire ar_hs = axi.arvalid & axi.arready;
  wire aw_hs = axi.awvalid & axi.awready;
  wire w_hs  = axi.wvalid & axi.wready;
  wire r_hs  = axi.rvalid & axi.rready;
  wire b_hs  = axi.bvalid & axi.bready;

  // slave state: wait counters, outstanding response, captured beats
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; rsp_cnt <= 0; w_beats <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      seen_araddr <= 32'd0; seen_awaddr <= 32'd0; seen_wdata <= 32'd0; seen_wstrb <= 4'd0;
    end else begin
      ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.wvalid  && !axi.wready)  ? w_cnt + 1  : 0;
      if ((r_pend && !axi.rvalid) || (b_pend && !axi.bvalid)) rsp_cnt <= rsp_cnt + 1;
      if (ar_hs) begin
        r_pend <= 1'b1; rsp_cnt <= 0; seen_araddr <= axi.araddr;
      end
      if (r_hs) r_pend <= 1'b0;
      if (aw_hs) seen_awaddr <= axi.awaddr;
      if (w_hs) begin
        seen_wdata <= axi.wdata; seen_wstrb <= axi.wstrb; w_beats <= w_beats + 1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && (aw_hs || w_hs)) begin
        b_pend <= 1'b1; rsp_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (b_hs) b_pend <= 1'b0;
    end
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        rd;
    logic [2:0]  f3;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ar_dly, aw_dly, w_dly, rsp_dly;
    logic [31:0] srdata;
    logic [1:0]  sresp;
    logic        misal;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [15:0] exp_arh, exp_awh, exp_wh;
  } vec_t;

  typedef struct {
    logic        rd;
    logic        misal;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] baddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs[NV];
  vec_t rst_vec;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e;
    int          cyc;
    int          beats0;
    logic [31:0] rd_before;
    logic [15:0] arh, awh, wh;
    logic        p_arw, p_aww, p_ww;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;
    string       tag;
    tag = $sformatf("v%0d", idx);
    cfg_ar_dly = v.ar_dly; cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly;
    cfg_rsp_dly = v.rsp_dly; cfg_rdata = v.srdata; cfg_resp = v.sresp;
    sb.push_back('{v.rd, v.misal, v.exp_err, v.exp_rdata, v.exp_baddr, v.exp_wstrb, v.exp_wdata});
    beats0 = w_beats;
    rd_before = rdata_out;
    req_valid = 1'b1; req_read = v.rd; req_write = ~v.rd;
    req_funct3 = v.f3; req_strb = v.strb; req_addr = v.addr; req_wdata = v.wdata;
    #1;
    if (v.misal) begin
      e = sb.pop_front();
      check({tag, "_misal_err"}, {31'd0, err}, {31'd0, e.err});
      check({tag, "_misal_stall_done"}, {30'd0, stall, done}, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1;
      check({tag, "_misal_err_pulse"}, {31'd0, err}, 32'd0);
      for (int k = 0; k < 3; k++) begin
        check({tag, "_misal_quiet"}, {28'd0, axi.arvalid, axi.awvalid, axi.wvalid, stall}, 32'd0);
        @(posedge clk); #1;
      end
      check({tag, "_misal_rdata_held"}, rdata_out, rd_before);
      return;
    end
    check({tag, "_c0_stall_err_done"}, {29'd0, stall, err, done}, 32'd4);
    arh = '0; awh = '0; wh = '0;
    arh[0] = axi.arvalid; awh[0] = axi.awvalid; wh[0] = axi.wvalid;
    cyc = 0;
    while (1) begin
      p_arw = axi.arvalid & ~axi.arready; p_araddr = axi.araddr;
      p_aww = axi.awvalid & ~axi.awready; p_awaddr = axi.awaddr;
      p_ww  = axi.wvalid & ~axi.wready;   p_wdata = axi.wdata; p_wstrb = axi.wstrb;
      @(posedge clk); #1;
      cyc++;
      if (cyc < 16) begin
        arh[cyc] = axi.arvalid; awh[cyc] = axi.awvalid; wh[cyc] = axi.wvalid;
      end
      if (p_arw) check({tag, "_ar_hold"}, {axi.arvalid, axi.araddr[30:0]}, {1'b1, p_araddr[30:0]});
      if (p_aww) check({tag, "_aw_hold"}, {axi.awvalid, axi.awaddr[30:0]}, {1'b1, p_awaddr[30:0]});
      if (p_ww)  check({tag, "_w_hold"}, {31'd0, axi.wvalid} | {27'd0, (axi.wdata != p_wdata) || (axi.wstrb != p_wstrb), 1'b0}, 32'd1);
      if (done) break;
      check({tag, "_busy_stall"}, {31'd0, stall}, 32'd1);
      if (cyc > 40) begin
        failures++;
        $display("FAIL %s_timeout actual=no_done expected=done_within_40", tag);
        break;
      end
    end
    e = sb.pop_front();
    check({tag, "_done_cycle"}, cyc, v.exp_cyc);
    check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_done_err"}, {31'd0, err}, {31'd0, e.err});
    if (e.rd) begin
      check({tag, "_rdata_out"}, rdata_out, e.rdata);
      check({tag, "_araddr"}, seen_araddr, e.baddr);
      check({tag, "_wbeats"}, w_beats - beats0, 32'd0);
    end else begin
      check({tag, "_rdata_held"}, rdata_out, rd_before);
      check({tag, "_awaddr"}, seen_awaddr, e.baddr);
      check({tag, "_wstrb"}, {28'd0, seen_wstrb}, {28'd0, e.wstrb});
      check({tag, "_wdata"}, seen_wdata, e.wdata);
      check({tag, "_wbeats"}, w_beats - beats0, 32'd1);
    end
    check({tag, "_arvalid_hist"}, {16'd0, arh}, {16'd0, v.exp_arh});
    check({tag, "_awvalid_hist"}, {16'd0, awh}, {16'd0, v.exp_awh});
    check({tag, "_wvalid_hist"}, {16'd0, wh}, {16'd0, v.exp_wh});
    req_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_after_done"}, {29'd0, done, err, stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rd    f3      strb     addr        wdata         ar aw w rsp srdata        resp   mis  cyc exp_rdata     err   baddr       wstrb    exp_wdata     arh      awh      wh
    vecs[0]  = '{1'b1, 3'b010, 4'b1111, 32'h100, 32'h0,        0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 1'b0, 3, 32'hDEADBEEF, 1'b0, 32'h100, 4'h0,    32'h0,        16'h02, 16'h00, 16'h00};
    vecs[1]  = '{1'b1, 3'b000, 4'b0001, 32'h103, 32'h0,        0, 0, 0, 0, 32'h80123456, 2'b00, 1'b0, 3, 32'hFFFFFF80, 1'b0, 32'h100, 4'h0,    32'h0,        16'h02, 16'h00, 16'h00};
    vecs[2]  = '{1'b1, 3'b100, 4'b0001, 32'h103, 32'h0,        0, 0, 0, 0, 32'h80123456, 2'b00, 1'b0, 3, 32'h00000080, 1'b0, 32'h100, 4'h0,    32'h0,        16'h02, 16'h00, 16'h00};
    vecs[3]  = '{1'b1, 3'b001, 4'b0011, 32'h102, 32'h0,        0, 0, 0, 0, 32'h80123456, 2'b00, 1'b0, 3, 32'hFFFF8012, 1'b0, 32'h100, 4'h0,    32'h0,        16'h02, 16'h00, 16'h00};
    vecs[4]  = '{1'b1, 3'b101, 4'b0011, 32'h102, 32'h0,        0, 0, 0, 0, 32'h80123456, 2'b00, 1'b0, 3, 32'h00008012, 1'b0, 32'h100, 4'h0,    32'h0,        16'h02, 16'h00, 16'h00};
    vecs[5]  = '{1'b1, 3'b000, 4'b0001, 32'h101, 32'h0,        0, 0, 0, 0, 32'h80123456, 2'b00, 1'b0, 3, 32'h00000034, 1'b0, 32'h100, 4'h0,    32'h0,        16'h02, 16'h00, 16'h00};
    vecs[6]  = '{1'b0, 3'b001, 4'b0011, 32'h102, 32'h0000ABCD, 0, 0, 0, 0, 32'h0,        2'b00, 1'b0, 3, 32'h0,        1'b0, 32'h100, 4'b1100, 32'hABCD0000, 16'h00, 16'h02, 16'h02};
    vecs[7]  = '{1'b0, 3'b010, 4'b1111, 32'h200, 32'h12345678, 0, 3, 0, 0, 32'h0,        2'b00, 1'b0, 6, 32'h0,        1'b0, 32'h200, 4'b1111, 32'h12345678, 16'h00, 16'h1E, 16'h02};
    vecs[8]  = '{1'b0, 3'b000, 4'b0001, 32'h203, 32'h000000A5, 0, 0, 2, 0, 32'h0,        2'b00, 1'b0, 5, 32'h0,        1'b0, 32'h200, 4'b1000, 32'hA5000000, 16'h00, 16'h02, 16'h0E};
    vecs[9]  = '{1'b1, 3'b010, 4'b1111, 32'h104, 32'h0,        1, 0, 0, 2, 32'hCAFEF00D, 2'b00, 1'b0, 6, 32'hCAFEF00D, 1'b0, 32'h104, 4'h0,    32'h0,        16'h06, 16'h00, 16'h00};
    vecs[10] = '{1'b1, 3'b010, 4'b1111, 32'h102, 32'h0,        0, 0, 0, 0, 32'h0,        2'b00, 1'b1, 0, 32'h0,        1'b1, 32'h0,   4'h0,    32'h0,        16'h00, 16'h00, 16'h00};
    vecs[11] = '{1'b1, 3'b001, 4'b0011, 32'h101, 32'h0,        0, 0, 0, 0, 32'h0,        2'b00, 1'b1, 0, 32'h0,        1'b1, 32'h0,   4'h0,    32'h0,        16'h00, 16'h00, 16'h00};
    vecs[12] = '{1'b0, 3'b010, 4'b1111, 32'h300, 32'h55AA55AA, 0, 0, 0, 0, 32'h0,        2'b10, 1'b0, 3, 32'h0,        1'b1, 32'h300, 4'b1111, 32'h55AA55AA, 16'h00, 16'h02, 16'h02};
    vecs[13] = '{1'b1, 3'b010, 4'b1111, 32'h300, 32'h0,        0, 0, 0, 0, 32'h11111111, 2'b11, 1'b0, 3, 32'h0,        1'b1, 32'h300, 4'h0,    32'h0,        16'h02, 16'h00, 16'h00};
    vecs[14] = '{1'b1, 3'b000, 4'b0001, 32'h102, 32'h0,        0, 0, 0, 0, 32'h00FF0000, 2'b00, 1'b0, 3, 32'hFFFFFFFF, 1'b0, 32'h100, 4'h0,    32'h0,        16'h02, 16'h00, 16'h00};
    rst_vec  = '{1'b1, 3'b010, 4'b1111, 32'h140, 32'h0,        0, 0, 0, 0, 32'h0BADF00D, 2'b00, 1'b0, 3, 32'h0BADF00D, 1'b0, 32'h140, 4'h0,    32'h0,        16'h02, 16'h00, 16'h00};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {26'd0, stall, done, err, axi.arvalid, axi.awvalid, axi.wvalid}, 32'd0);
    check("reset_ready", {30'd0, axi.rready, axi.bready}, 32'd0);
    check("reset_rdata_out", rdata_out, 32'd0);
    check("reset_addr", axi.awaddr | axi.araddr, 32'd0);
    check("reset_wdata_wstrb", axi.wdata | {28'd0, axi.wstrb}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // reset while waiting in RD_R with rvalid low
    cfg_ar_dly = 0; cfg_aw_dly = 0; cfg_w_dly = 0; cfg_rsp_dly = 5;
    cfg_rdata = 32'h77777777; cfg_resp = 2'b00;
    sb.push_back('{1'b1, 1'b0, 1'b0, 32'h77777777, 32'h140, 4'h0, 32'h0});
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_funct3 = 3'b010; req_strb = 4'b1111; req_addr = 32'h140;
    #1;
    check("rst_seq_c0_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_seq_in_rd_r", {29'd0, axi.rready, axi.rvalid, stall}, 32'd5);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_seq_quiet", {27'd0, axi.arvalid, axi.rready, stall, done, err}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_seq_idle", {28'd0, stall, done, axi.arvalid, axi.rready}, 32'd0);
    check("rst_seq_rdata_cleared", rdata_out, 32'd0);
    run_vec(rst_vec, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
